// File: rtl/ffm.sv
`default_nettype none
// ============================================================================
// Module   : ffm
// Brief    : Sequential GF(2^255-19) multiplier, MSB-first double-and-add,
//            one multiplier bit per clock, 255-cycle fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
module ffm (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [254:0] a_i,
    input  logic [254:0] b_i,
    output logic [254:0] out,
    output logic         done,
    output logic         busy
);

    localparam logic [255:0] C_P = (256'd1 << 255) - 256'd19;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state_q;
    logic [254:0] a_q;
    logic [254:0] b_q;
    logic [254:0] acc_q;
    logic [7:0]   cnt_q;
    logic [254:0] out_q;
    logic         done_q;

    logic [255:0] w_dbl;
    logic [254:0] w_t;
    logic [255:0] w_sum;
    logic [254:0] acc_d;

    // acc < p is kept as an invariant, so each half-step needs at most one subtract.
    always_comb begin
        w_dbl = {acc_q, 1'b0};
        w_t   = w_dbl[254:0];
        if (w_dbl >= C_P) begin
            w_t = 255'(w_dbl - C_P);
        end
        w_sum = {1'b0, w_t} + {1'b0, a_q};
        acc_d = w_t;
        if (b_q[cnt_q]) begin
            acc_d = w_sum[254:0];
            if (w_sum >= C_P) begin
                acc_d = 255'(w_sum - C_P);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        acc_q   <= '0;
                        cnt_q   <= 8'd254;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == 8'd0) begin
                        out_q   <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign busy = (state_q == RUN);

endmodule
`default_nettype wire
